// File: rtl/llc_pkg.sv
// Shared types for the LLC event scheduler: FSM state codes and event-entry sizing.
package llc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_COMMIT = 3'd2
    } llc_state_t;

    // Entry layout, MSB to LSB: {data, new flags, periodic, ts}
    function automatic int unsigned entry_width(input int unsigned num_inputs,
                                                input int unsigned data_w,
                                                input int unsigned ts_w);
        return num_inputs * data_w + num_inputs + 1 + ts_w;
    endfunction

endpackage

// File: rtl/llc_event_fifo.sv
// Synchronous event FIFO; pointers carry an extra wrap bit to tell full from empty.
module llc_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             push_ok,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push while full still lands
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/llc_event_scheduler.sv
// Low-level controller: queues input/periodic events and walks each one through
// the evaluation layers, one layer per cycle, followed by a commit strobe.
module llc_event_scheduler
    import llc_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_INPUTS  = 2,
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned TS_W        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]        in_new,
    input  logic                         periodic_tick,
    output logic                         q_push,
    output logic                         q_push_valid,
    output logic                         q_pop,
    output logic                         q_pop_valid,
    output logic                         overflow,
    output logic [2:0]                   llc_state,
    output logic [NUM_LAYERS-1:0]        layer_en,
    output logic [NUM_INPUTS*DATA_W-1:0] cur_data,
    output logic [NUM_INPUTS-1:0]        cur_new,
    output logic                         cur_periodic,
    output logic [TS_W-1:0]              cur_ts,
    output logic                         commit
);

    localparam int unsigned EW    = entry_width(NUM_INPUTS, DATA_W, TS_W);
    localparam int unsigned LW    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned P_BIT = TS_W;
    localparam int unsigned N_LSB = TS_W + 1;
    localparam int unsigned D_LSB = TS_W + 1 + NUM_INPUTS;

    llc_state_t      state, state_nxt;
    logic [LW-1:0]   layer, layer_nxt;
    logic [TS_W-1:0] ts;
    logic [EW-1:0]   wr_entry, rd_entry;
    logic            fifo_full, fifo_empty, push_ok, pop_req;

    // Gated by rst so the push strobe drops in the same cycle reset asserts
    assign q_push       = en & ~rst & ((|in_new) | periodic_tick);
    assign q_push_valid = push_ok;
    assign q_pop        = pop_req;
    assign q_pop_valid  = pop_req;
    assign llc_state    = state;
    assign wr_entry     = {in_data, in_new, periodic_tick, ts};

    llc_event_fifo #(
        .WIDTH (EW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (q_push),
        .pop     (pop_req),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .push_ok (push_ok),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        pop_req   = 1'b0;
        layer_en  = '0;
        commit    = 1'b0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop_req   = 1'b1;
                        layer_nxt = '0;
                        state_nxt = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    layer_en = NUM_LAYERS'(1) << layer;
                    if (layer == LW'(NUM_LAYERS - 1)) state_nxt = ST_COMMIT;
                    else                              layer_nxt = layer + LW'(1);
                end
                ST_COMMIT: begin
                    commit = 1'b1;
                    if (!fifo_empty) begin
                        pop_req   = 1'b1;
                        layer_nxt = '0;
                        state_nxt = ST_EVAL;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            layer    <= '0;
            ts       <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            layer <= layer_nxt;
            if (en) ts <= ts + TS_W'(1);
            if (q_push && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_data     <= '0;
            cur_new      <= '0;
            cur_periodic <= 1'b0;
            cur_ts       <= '0;
        end else if (pop_req) begin
            cur_data     <= rd_entry[D_LSB +: NUM_INPUTS*DATA_W];
            cur_new      <= rd_entry[N_LSB +: NUM_INPUTS];
            cur_periodic <= rd_entry[P_BIT];
            cur_ts       <= rd_entry[TS_W-1:0];
        end
    end

endmodule
